// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the CPU/DMA memory bus arbiter: FSM state encoding
// and the default burst limit.
package mem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_CPU_OWN  = 3'd0,
        ARB_DRAIN    = 3'd1,
        ARB_GAP      = 3'd2,
        ARB_DMA_OWN  = 3'd3,
        ARB_HANDBACK = 3'd4
    } arb_state_t;

    localparam int DEFAULT_HOLD_MAX = 16;

endpackage

// File: rtl/mem_bus_arbiter_burst_counter.sv
// Burst transfer counter for one DMA grant. It clears, counts transfers and
// flags both the final transfer and the limit.
module arb_burst_counter #(
    parameter int HOLD_MAX = 16,
    parameter int CW       = $clog2(HOLD_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          last,
    output logic          limit
);

    logic [CW-1:0] count_reg;

    // Saturating increment, so the count can never pass HOLD_MAX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc && !limit) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
    assign last  = (count_reg == CW'(HOLD_MAX - 1));
    assign limit = (count_reg == CW'(HOLD_MAX));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter. The CPU owns the bus by default. A DMA request is taken
// at a CPU instruction boundary and the bus is returned after a bounded burst.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int HOLD_MAX = DEFAULT_HOLD_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_dout,
    input  logic              cpu_oe,
    input  logic              cpu_we_n,
    input  logic              cpu_boundary,
    output logic              cpu_run,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_dout,
    output logic              dma_gnt,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dout,
    output logic              mem_drive,
    output logic              mem_we_n
);

    localparam int CW = $clog2(HOLD_MAX + 1);

    arb_state_t    state_reg, state_next;
    logic          progress_reg, progress_next;
    logic [CW-1:0] burst_count;
    logic          burst_last, burst_limit;
    logic          transfer, count_clear;

    assign transfer    = (state_reg == ARB_DMA_OWN) && dma_req;
    assign count_clear = (state_reg == ARB_HANDBACK);

    arb_burst_counter #(
        .HOLD_MAX (HOLD_MAX),
        .CW       (CW)
    ) u_burst_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (count_clear),
        .inc   (transfer),
        .count (burst_count),
        .last  (burst_last),
        .limit (burst_limit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ARB_CPU_OWN;
            progress_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            progress_reg <= progress_next;
        end
    end

    // progress gates re-entry to DRAIN: after a forced release the CPU must
    // retire one instruction before the DMA may take the bus again.
    always_comb begin
        state_next    = state_reg;
        progress_next = progress_reg;
        case (state_reg)
            ARB_CPU_OWN: begin
                if (cpu_boundary) progress_next = 1'b1;
                if (dma_req && progress_reg) state_next = ARB_DRAIN;
            end
            ARB_DRAIN: begin
                if (!dma_req)          state_next = ARB_CPU_OWN;
                else if (cpu_boundary) state_next = ARB_GAP;
            end
            ARB_GAP: begin
                state_next = dma_req ? ARB_DMA_OWN : ARB_HANDBACK;
            end
            ARB_DMA_OWN: begin
                if (!dma_req || burst_last) state_next = ARB_HANDBACK;
            end
            ARB_HANDBACK: begin
                // The counter still holds the burst length here, so hitting the
                // limit means the release was forced.
                progress_next = !burst_limit;
                state_next    = ARB_CPU_OWN;
            end
            default: begin
                state_next = ARB_CPU_OWN;
            end
        endcase
    end

    always_comb begin
        cpu_run   = 1'b0;
        dma_gnt   = 1'b0;
        dma_ack   = 1'b0;
        mem_addr  = cpu_addr;
        mem_dout  = cpu_dout;
        mem_drive = 1'b0;
        mem_we_n  = 1'b1;
        case (state_reg)
            ARB_CPU_OWN, ARB_DRAIN: begin
                cpu_run   = 1'b1;
                mem_drive = cpu_oe;
                mem_we_n  = cpu_we_n | ~rst;
            end
            ARB_DMA_OWN: begin
                dma_gnt   = 1'b1;
                dma_ack   = dma_req;
                mem_addr  = dma_addr;
                mem_dout  = dma_dout;
                mem_drive = dma_we;
                // A write strobe only goes out while a transfer is actually requested.
                mem_we_n  = ~(dma_we & dma_req);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with HOLD_MAX=4. It covers reset,
// a single write, a forced release, an abort in DRAIN and a reset mid-burst.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_oe, cpu_we_n, cpu_boundary, cpu_run;
    logic        dma_req, dma_we, dma_gnt, dma_ack;
    logic [15:0] dma_addr, mem_addr;
    logic [7:0]  dma_dout, mem_dout;
    logic        mem_drive, mem_we_n;

    int n_vec = 0;
    int n_err = 0;
    int acks;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .HOLD_MAX(4)) dut (
        .clk (clk), .rst (rst),
        .cpu_addr (cpu_addr), .cpu_dout (cpu_dout), .cpu_oe (cpu_oe),
        .cpu_we_n (cpu_we_n), .cpu_boundary (cpu_boundary), .cpu_run (cpu_run),
        .dma_req (dma_req), .dma_we (dma_we), .dma_addr (dma_addr),
        .dma_dout (dma_dout), .dma_gnt (dma_gnt), .dma_ack (dma_ack),
        .mem_addr (mem_addr), .mem_dout (mem_dout), .mem_drive (mem_drive),
        .mem_we_n (mem_we_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and check the ownership invariants on every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("gnt_and_run_exclusive", 32'(dma_gnt & cpu_run), 32'd0);
        if (!cpu_run && !dma_gnt) chk("idle_bus_no_write", 32'(mem_we_n), 32'd1);
    endtask

    initial begin
        rst = 1'b0; cpu_addr = 16'hBEEF; cpu_dout = 8'h3C; cpu_oe = 1'b1;
        cpu_we_n = 1'b0; cpu_boundary = 1'b0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0000; dma_dout = 8'h00;

        // Reset held with a DMA request pending
        #3;
        $display("step: reset asserted");
        chk("rst_cpu_run", 32'(cpu_run), 32'd1);
        chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("rst_dma_ack", 32'(dma_ack), 32'd0);
        chk("rst_mem_we_n", 32'(mem_we_n), 32'd1);
        chk("rst_mem_drive", 32'(mem_drive), 32'd1);
        tick();
        chk("rst_state_hold", 32'(dut.state_reg), 32'(ARB_CPU_OWN));
        @(negedge clk);
        rst = 1'b1;
        tick();
        $display("step: reset released, expect DRAIN");
        chk("drain_first_edge", 32'(dut.state_reg), 32'(ARB_DRAIN));
        chk("drain_cpu_run", 32'(cpu_run), 32'd1);
        chk("drain_passthru_we_n", 32'(mem_we_n), 32'd0);
        chk("drain_passthru_addr", 32'(mem_addr), 32'hBEEF);

        // Single DMA write, boundary arrives 3 cycles after the request
        dma_we = 1'b1; dma_addr = 16'h1234; dma_dout = 8'hA5;
        tick();
        tick();
        chk("drain_wait", 32'(dut.state_reg), 32'(ARB_DRAIN));
        cpu_boundary = 1'b1;
        tick();
        cpu_boundary = 1'b0;
        $display("step: GAP cycle");
        chk("gap_state", 32'(dut.state_reg), 32'(ARB_GAP));
        chk("gap_cpu_run", 32'(cpu_run), 32'd0);
        chk("gap_mem_drive", 32'(mem_drive), 32'd0);
        chk("gap_mem_addr", 32'(mem_addr), 32'hBEEF);
        tick();
        $display("step: DMA write 0x1234 <= 0xA5");
        chk("wr_dma_gnt", 32'(dma_gnt), 32'd1);
        chk("wr_dma_ack", 32'(dma_ack), 32'd1);
        chk("wr_mem_we_n", 32'(mem_we_n), 32'd0);
        chk("wr_mem_addr", 32'(mem_addr), 32'h1234);
        chk("wr_mem_dout", 32'(mem_dout), 32'hA5);
        chk("wr_mem_drive", 32'(mem_drive), 32'd1);
        tick();
        dma_req = 1'b0;
        #1;
        chk("wr_done_ack", 32'(dma_ack), 32'd0);
        chk("wr_done_we_n", 32'(mem_we_n), 32'd1);
        chk("wr_count", 32'(dut.burst_count), 32'd1);
        tick();
        $display("step: HANDBACK after write");
        chk("hb_state", 32'(dut.state_reg), 32'(ARB_HANDBACK));
        chk("hb_cpu_run", 32'(cpu_run), 32'd0);
        chk("hb_dma_gnt", 32'(dma_gnt), 32'd0);
        tick();
        chk("hb_resume_run", 32'(cpu_run), 32'd1);
        chk("hb_count_clear", 32'(dut.burst_count), 32'd0);
        chk("cpu_pass_addr", 32'(mem_addr), 32'hBEEF);
        chk("cpu_pass_we_n", 32'(mem_we_n), 32'd0);

        // Abort in DRAIN
        dma_req = 1'b1;
        tick();
        $display("step: abort in DRAIN");
        chk("abort_drain", 32'(dut.state_reg), 32'(ARB_DRAIN));
        dma_req = 1'b0;
        tick();
        chk("abort_back", 32'(dut.state_reg), 32'(ARB_CPU_OWN));
        chk("abort_run", 32'(cpu_run), 32'd1);
        chk("abort_gnt", 32'(dma_gnt), 32'd0);

        // Forced release after 4 read transfers
        dma_we = 1'b0; dma_addr = 16'h0040;
        dma_req = 1'b1;
        tick();
        cpu_boundary = 1'b1;
        tick();
        cpu_boundary = 1'b0;
        chk("force_gap", 32'(dut.state_reg), 32'(ARB_GAP));
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dma_ack) acks++;
        end
        $display("step: forced release, %0d acks", acks);
        chk("force_ack_count", 32'(acks), 32'd4);
        chk("force_stays_cpu", 32'(dut.state_reg), 32'(ARB_CPU_OWN));
        chk("force_progress", 32'(dut.progress_reg), 32'd0);
        chk("force_count_max", 32'(dut.burst_count), 32'd0);
        cpu_boundary = 1'b1;
        tick();
        cpu_boundary = 1'b0;
        chk("fair_still_cpu", 32'(dut.state_reg), 32'(ARB_CPU_OWN));
        tick();
        $display("step: re-entry to DRAIN after boundary");
        chk("fair_drain", 32'(dut.state_reg), 32'(ARB_DRAIN));

        // Reset during the second transfer of a burst
        cpu_boundary = 1'b1;
        tick();
        cpu_boundary = 1'b0;
        tick();
        chk("mid_first_ack", 32'(dma_ack), 32'd1);
        tick();
        chk("mid_second_gnt", 32'(dma_gnt), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        $display("step: reset mid-burst");
        chk("mid_rst_gnt", 32'(dma_gnt), 32'd0);
        chk("mid_rst_run", 32'(cpu_run), 32'd1);
        chk("mid_rst_count", 32'(dut.burst_count), 32'd0);
        chk("mid_rst_we_n", 32'(mem_we_n), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        dma_req = 1'b0;
        tick();
        chk("post_rst_state", 32'(dut.state_reg), 32'(ARB_CPU_OWN));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
